// File: rtl/car_sensor_cond.sv
// Country-road loop detector conditioning: synchronise, debounce, queue vehicles, drain on GREEN, and raise X.
// Optional pedestrian request term enabled with `define PED_REQ_EN.
module car_sensor_cond #(
    parameter int DEB_CYCLES   = 4,
    parameter int CNT_W        = 4,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             raw_sensor,
`ifdef PED_REQ_EN
    input  logic             ped_btn,
`endif
    input  logic [1:0]       cntry,
    output logic             X,
    output logic             present,
    output logic             arrival,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0]    TMR_LAST = TW'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [1:0]       GREEN    = 2'd2;

    typedef enum logic [1:0] {
        ABSENT  = 2'd0,
        ARM_ON  = 2'd1,
        PRESENT = 2'd2,
        ARM_OFF = 2'd3
    } deb_state_t;

    deb_state_t    state;
    logic [DW-1:0] deb_cnt;
    logic [TW-1:0] drain_tmr;
    logic          sync1, s;
    logic          green, drain_dec;

    assign dbg_state = state;
    assign green     = (cntry == GREEN);
    assign drain_dec = green && (wait_cnt != '0) && (drain_tmr == TMR_LAST);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw_sensor;
            s     <= sync1;
        end
    end

    // Debounce: a level change is accepted only after DEB_CYCLES identical samples.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state   <= ABSENT;
            deb_cnt <= '0;
            present <= 1'b0;
            arrival <= 1'b0;
        end else begin
            arrival <= 1'b0;
            case (state)
                ABSENT: begin
                    if (s) begin
                        state   <= ARM_ON;
                        deb_cnt <= DW'(1);
                    end
                end
                ARM_ON: begin
                    if (!s) begin
                        state   <= ABSENT;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state   <= PRESENT;
                        deb_cnt <= '0;
                        present <= 1'b1;
                        arrival <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                PRESENT: begin
                    if (!s) begin
                        state   <= ARM_OFF;
                        deb_cnt <= DW'(1);
                    end
                end
                ARM_OFF: begin
                    if (s) begin
                        state   <= PRESENT;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state   <= ABSENT;
                        deb_cnt <= '0;
                        present <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                default: begin
                    state   <= ABSENT;
                    deb_cnt <= '0;
                    present <= 1'b0;
                end
            endcase
        end
    end

    // Partial service is discarded whenever GREEN ends or the queue empties.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            drain_tmr <= '0;
        end else if (green && (wait_cnt != '0)) begin
            drain_tmr <= drain_dec ? '0 : drain_tmr + TW'(1);
        end else begin
            drain_tmr <= '0;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            wait_cnt <= '0;
            overflow <= 1'b0;
        end else if (arrival && !drain_dec) begin
            if (wait_cnt == CNT_MAX) overflow <= 1'b1;
            else                     wait_cnt <= wait_cnt + CNT_W'(1);
        end else if (!arrival && drain_dec) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

`ifdef PED_REQ_EN
    logic ped_s1, ped_s2, ped_s3, ped_pend;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            ped_s1   <= 1'b0;
            ped_s2   <= 1'b0;
            ped_s3   <= 1'b0;
            ped_pend <= 1'b0;
        end else begin
            ped_s1 <= ped_btn;
            ped_s2 <= ped_s1;
            ped_s3 <= ped_s2;
            if (green)                 ped_pend <= 1'b0;
            else if (ped_s2 && !ped_s3) ped_pend <= 1'b1;
        end
    end

    assign X = present | (wait_cnt != '0) | ped_pend;
`else
    assign X = present | (wait_cnt != '0);
`endif

endmodule

// File: tb/tb_car_sensor_cond.sv
// Directed bench for car_sensor_cond: expected snapshots and arrival edges are queued by
// the stimulus and checked by an independent negedge monitor.
module tb_car_sensor_cond;

    localparam int CNT_W = 4;
    localparam int W     = CNT_W + 4;

    logic             clock = 1'b0;
    logic             clear_n = 1'b0;
    logic             raw_sensor = 1'b0;
    logic [1:0]       cntry = 2'd0;
`ifdef PED_REQ_EN
    logic             ped_btn = 1'b0;
`endif
    logic             X, present, arrival, overflow;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       dbg_state;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           arr_q[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    car_sensor_cond #(.DEB_CYCLES(4), .CNT_W(CNT_W), .DRAIN_CYCLES(8)) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .raw_sensor (raw_sensor),
`ifdef PED_REQ_EN
        .ped_btn    (ped_btn),
`endif
        .cntry      (cntry),
        .X          (X),
        .present    (present),
        .arrival    (arrival),
        .wait_cnt   (wait_cnt),
        .overflow   (overflow),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d checks still queued", exp_q.size());
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_state(input string nm, input logic x, input logic p, input logic a,
                                input logic o, input logic [CNT_W-1:0] wc);
        exp_q.push_back({x, p, a, o, wc});
        name_q.push_back(nm);
    endtask

    // Raw high for hi clocks, then low long enough for the debouncer to return to ABSENT.
    task automatic car(input int hi, input bit expect_arr);
        if (expect_arr) arr_q.push_back(cyc + 6);
        raw_sensor = 1'b1;
        tick(hi);
        raw_sensor = 1'b0;
        tick(8);
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        string        nm;
        int           e;
        if (arrival) begin
            n_checks++;
            if (arr_q.size() == 0) begin
                n_fail++;
                $display("FAIL arrival_unexpected: pulse at edge %0d, none required", cyc);
            end else begin
                e = arr_q.pop_front();
                if (e != cyc) begin
                    n_fail++;
                    $display("FAIL arrival_edge: pulse at edge %0d, required edge %0d", cyc, e);
                end
            end
        end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {X, present, arrival, overflow, wait_cnt};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s: {X,present,arrival,overflow,wait_cnt} got %b_%b_%b_%b_%0d required %b_%b_%b_%b_%0d",
                         nm, act_v[W-1], act_v[W-2], act_v[W-3], act_v[W-4], act_v[CNT_W-1:0],
                         exp_v[W-1], exp_v[W-2], exp_v[W-3], exp_v[W-4], exp_v[CNT_W-1:0]);
            end
        end
    end

    initial begin
        tick(2);
        expect_state("reset_state", 0, 0, 0, 0, 0);
        tick(1);
        clear_n = 1'b1;
        tick(2);

        // glitch rejection and a clean arrival
        car(3, 0);
        expect_state("glitch_3", 0, 0, 0, 0, 0);
        car(6, 1);
        expect_state("clean_6", 1, 0, 0, 0, 1);

        // drain at 8 GREEN cycles per vehicle
        car(6, 1);
        car(6, 1);
        expect_state("queue_3", 1, 0, 0, 0, 3);
        cntry = 2'd2;
        tick(16);
        expect_state("drain_16", 1, 0, 0, 0, 1);
        tick(4);
        cntry = 2'd0;
        tick(10);
        expect_state("red_hold", 1, 0, 0, 0, 1);
        cntry = 2'd3;
        tick(10);
        expect_state("illegal_cntry", 1, 0, 0, 0, 1);
        cntry = 2'd2;
        tick(7);
        expect_state("no_carry_7", 1, 0, 0, 0, 1);
        tick(1);
        expect_state("drain_empty", 0, 0, 0, 0, 0);
        cntry = 2'd0;
        tick(2);

        // arrival coincident with a drain decrement
        car(6, 1);
        car(6, 1);
        expect_state("queue_2", 1, 0, 0, 0, 2);
        cntry = 2'd2;
        tick(1);
        arr_q.push_back(cyc + 6);
        raw_sensor = 1'b1;
        tick(6);
        raw_sensor = 1'b0;
        tick(1);
        cntry = 2'd0;
        expect_state("simultaneous", 1, 1, 0, 0, 2);

        // reset while a vehicle is present and the queue is non-empty
        tick(1);
        clear_n = 1'b0;
        expect_state("midop_reset", 0, 0, 0, 0, 0);
        tick(2);
        clear_n = 1'b1;
        tick(2);

        // saturation
        repeat (15) car(6, 1);
        expect_state("queue_full", 1, 0, 0, 0, 15);
        car(6, 1);
        car(6, 1);
        expect_state("saturated", 1, 0, 0, 1, 15);
        cntry = 2'd2;
        tick(120);
        expect_state("drain_all", 0, 0, 0, 1, 0);
        cntry = 2'd0;
        tick(2);

`ifdef PED_REQ_EN
        ped_btn = 1'b1;
        tick(1);
        ped_btn = 1'b0;
        tick(1);
        expect_state("ped_edge2", 0, 0, 0, 1, 0);
        tick(1);
        expect_state("ped_edge3", 1, 0, 0, 1, 0);
        cntry = 2'd2;
        tick(1);
        expect_state("ped_green", 0, 0, 0, 1, 0);
        cntry = 2'd0;
        tick(2);
`endif

        tick(2);
        n_checks++;
        if (exp_q.size() != 0 || arr_q.size() != 0) begin
            n_fail++;
            $display("FAIL queues_drained: %0d state checks and %0d arrivals left, required 0 and 0",
                     exp_q.size(), arr_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
